outagu: RTL

- Write-side address generator for MVU output results; the counterpart of the input/weight read AGU.
- Each step presents one bit-plane word of an output vector. Planes are written MSB first, oprecision words per vector, at consecutive addresses.
- The block walks a 3-level strided loop over output vectors and issues a registered write address and write strobe to the data memory bank.
- It signals when the last word of the job has been written.

---
 rtl/outagu_if.sv | 32 +++
 rtl/outagu.sv | 93 +++++++++
 2 files changed

// File: rtl/outagu_if.sv
// outagu_if: control, configuration and write-port bundle for the output AGU.
interface outagu_if #(
  parameter int BPREC    = 6,
  parameter int BDBANKA  = 15,
  parameter int BWLENGTH = 8
);
  logic                start;
  logic                step;
  logic [BPREC-1:0]    oprecision;
  logic [BDBANKA-1:0]  ostride0;
  logic [BDBANKA-1:0]  ostride1;
  logic [BDBANKA-1:0]  ostride2;
  logic [BWLENGTH-1:0] olength0;
  logic [BWLENGTH-1:0] olength1;
  logic [BWLENGTH-1:0] olength2;
  logic [BDBANKA-1:0]  obaseaddr;
  logic [BDBANKA-1:0]  addr_out;
  logic                wr_en;
  logic                omsb;
  logic                busy;
  logic                done;
  modport master (
    output start, step, oprecision, ostride0, ostride1, ostride2,
           olength0, olength1, olength2, obaseaddr,
    input  addr_out, wr_en, omsb, busy, done
  );
  modport slave (
    input  start, step, oprecision, ostride0, ostride1, ostride2,
           olength0, olength1, olength2, obaseaddr,
    output addr_out, wr_en, omsb, busy, done
  );
endinterface

// File: rtl/outagu.sv
// outagu: write-side AGU walking a 3-level strided loop over output vectors,
// one registered write per step, planes MSB first at consecutive addresses.
module outagu #(
  parameter int BPREC    = 6,
  parameter int BDBANKA  = 15,
  parameter int BWLENGTH = 8
) (
  input  logic    clk,
  input  logic    clr,
  outagu_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t              r_state, w_next;
  logic [BPREC-1:0]    r_prec, r_cnt_b, w_pm1;
  logic [BDBANKA-1:0]  r_s0, r_s1, r_s2, r_a0, r_a1, r_a2, r_addr;
  logic [BWLENGTH-1:0] r_l0, r_l1, r_l2, r_cnt0, r_cnt1, r_cnt2;
  logic                r_wr_en, r_omsb, r_done;
  logic                w_go, w_end_b, w_end0, w_end1, w_end2, w_final;
  // oprecision of 0 behaves as a single plane
  assign w_pm1   = (r_prec == '0) ? '0 : r_prec - BPREC'(1);
  assign w_go    = (r_state == RUN) && bus.step;
  assign w_end_b = !(r_cnt_b < w_pm1);
  assign w_end0  = !(r_cnt0 < r_l0);
  assign w_end1  = !(r_cnt1 < r_l1);
  assign w_end2  = !(r_cnt2 < r_l2);
  assign w_final = w_go && w_end_b && w_end0 && w_end1 && w_end2;
  always_ff @(posedge clk)
    r_state <= clr ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = bus.start ? RUN : IDLE;
    else w_next = w_final ? IDLE : RUN;
  end
  always_comb begin
    bus.busy     = (r_state == RUN);
    bus.addr_out = r_addr;
    bus.wr_en    = r_wr_en;
    bus.omsb     = r_omsb;
    bus.done     = r_done;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      {r_prec, r_cnt_b} <= '0;
      {r_s0, r_s1, r_s2, r_a0, r_a1, r_a2, r_addr} <= '0;
      {r_l0, r_l1, r_l2, r_cnt0, r_cnt1, r_cnt2} <= '0;
      {r_wr_en, r_omsb, r_done} <= '0;
    end else begin
      r_wr_en <= w_go;
      r_done  <= w_final;
      if (w_go) begin
        r_addr <= r_a0 + BDBANKA'(r_cnt_b);
        r_omsb <= (r_cnt_b == '0);
      end
      if (r_state == IDLE && bus.start) begin
        r_prec <= bus.oprecision;
        r_s0   <= bus.ostride0;
        r_s1   <= bus.ostride1;
        r_s2   <= bus.ostride2;
        r_l0   <= bus.olength0;
        r_l1   <= bus.olength1;
        r_l2   <= bus.olength2;
        r_a0   <= bus.obaseaddr;
        r_a1   <= bus.obaseaddr;
        r_a2   <= bus.obaseaddr;
        {r_cnt_b, r_cnt0, r_cnt1, r_cnt2} <= '0;
      end else if (w_go) begin
        if (!w_end_b) r_cnt_b <= r_cnt_b + BPREC'(1);
        else begin
          r_cnt_b <= '0;
          if (!w_end0) begin
            r_cnt0 <= r_cnt0 + BWLENGTH'(1);
            r_a0   <= r_a0 + r_s0;
          end else begin
            r_cnt0 <= '0;
            if (!w_end1) begin
              r_cnt1 <= r_cnt1 + BWLENGTH'(1);
              r_a1   <= r_a1 + r_s1;
              r_a0   <= r_a1 + r_s1;
            end else begin
              r_cnt1 <= '0;
              if (!w_end2) begin
                r_cnt2 <= r_cnt2 + BWLENGTH'(1);
                r_a2   <= r_a2 + r_s2;
                r_a1   <= r_a2 + r_s2;
                r_a0   <= r_a2 + r_s2;
              end else r_cnt2 <= '0;
            end
          end
        end
      end
    end
  end
endmodule
